// File: rtl/aes_pkg.sv
// Shared AES helpers: state byte addressing, ShiftRows offsets and NB legality.
// Column-major byte layout with byte 0 (row 0, col 0) in the MSBs of the state.
package aes_pkg;

    localparam int AES_ROWS = 4;

    function automatic bit aes_nb_legal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    // MSB bit index of byte (row r, column c) in a 32*nb-bit state vector.
    function automatic int aes_byte_msb(input int nb, input int r, input int c);
        return 32 * nb - 1 - 8 * (AES_ROWS * c + r);
    endfunction

    // Rijndael ShiftRows offset Cr; wide blocks (NB = 8) shift rows 2 and 3 one further.
    function automatic int aes_row_shift(input int nb, input int r);
        int shift;
        case (r)
            0:       shift = 0;
            1:       shift = 1;
            2:       shift = (nb == 8) ? 3 : 2;
            default: shift = (nb == 8) ? 4 : 3;
        endcase
        return shift;
    endfunction

endpackage

// File: rtl/aes_shift_rows_perm.sv
// Combinational (Inv)ShiftRows byte permutation for a Rijndael state of NB columns.
// Pure wiring plus one 2:1 mux per byte; shared by registered and unregistered paths.
module aes_shift_rows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] in,
    input  logic             inv,
    output logic [32*NB-1:0] out
);

    if (!aes_nb_legal(NB)) begin : g_bad_nb
        $error("aes_shift_rows_perm: NB must be 4, 6 or 8");
    end

    logic [32*NB-1:0] fwd_perm;
    logic [32*NB-1:0] inv_perm;

    for (genvar gi = 0; gi < AES_ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < NB; gj++) begin : g_col
            localparam int SHIFT   = aes_row_shift(NB, gi);
            localparam int FWD_SRC = (gj + SHIFT) % NB;
            localparam int INV_SRC = (gj - SHIFT + NB) % NB;
            localparam int DST_MSB = aes_byte_msb(NB, gi, gj);
            localparam int FWD_MSB = aes_byte_msb(NB, gi, FWD_SRC);
            localparam int INV_MSB = aes_byte_msb(NB, gi, INV_SRC);

            assign fwd_perm[DST_MSB -: 8] = in[FWD_MSB -: 8];
            assign inv_perm[DST_MSB -: 8] = in[INV_MSB -: 8];
        end
    end

    assign out = inv ? inv_perm : fwd_perm;

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// Registered (Inv)ShiftRows stage: permutation ahead of a main register plus one skid
// register, giving a fully registered in_ready and 1 beat/cycle sustained throughput.
module aes_shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [32*NB-1:0] in_data,
    input  logic             in_inv,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [32*NB-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       occupancy
);

    if (TAG_W < 1) begin : g_bad_tag
        $error("aes_shift_rows_pipe: TAG_W must be >= 1");
    end

    logic [32*NB-1:0] perm_data;

    logic             main_valid_q, main_valid_d;
    logic [32*NB-1:0] main_data_q,  main_data_d;
    logic [TAG_W-1:0] main_tag_q,   main_tag_d;
    logic             skid_valid_q, skid_valid_d;
    logic [32*NB-1:0] skid_data_q,  skid_data_d;
    logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
    logic             in_ready_q;
    logic [1:0]       occ_q, occ_d;

    logic accept;
    logic main_free;

    aes_shift_rows_perm #(
        .NB (NB)
    ) u_perm (
        .in  (in_data),
        .inv (in_inv),
        .out (perm_data)
    );

    assign accept    = in_valid & in_ready_q;
    // Main can take a new beat when empty or when its current beat leaves this cycle.
    assign main_free = !main_valid_q | out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_tag_d   = main_tag_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_tag_d   = skid_tag_q;

        if (main_free) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_tag_d   = skid_tag_q;
                if (accept) begin
                    skid_data_d = perm_data;
                    skid_tag_d  = in_tag;
                end else begin
                    skid_valid_d = 1'b0;
                end
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_data_d  = perm_data;
                main_tag_d   = in_tag;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = perm_data;
            skid_tag_d   = in_tag;
        end

        occ_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_tag_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_tag_q   <= '0;
            in_ready_q   <= 1'b0;
            occ_q        <= 2'd0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_tag_q   <= main_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_tag_q   <= skid_tag_d;
            in_ready_q   <= !skid_valid_d;
            occ_q        <= occ_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_tag   = main_tag_q;
    assign occupancy = occ_q;

endmodule
